// File: rtl/draw_rect_fill_pkg.sv
// Shared constants, enums and per-mode pixel rules for the rectangle rasteriser.
package draw_rect_fill_pkg;

    localparam int X_W_DEF      = 8;
    localparam int Y_W_DEF      = 7;
    localparam int COLOUR_W_DEF = 3;
    localparam int SCREEN_W_DEF = 160;
    localparam int SCREEN_H_DEF = 120;

    typedef enum logic [1:0] {
        MODE_SOLID    = 2'd0,
        MODE_OUTLINE  = 2'd1,
        MODE_CHECKER  = 2'd2,
        MODE_BORDERED = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Outline mode only draws the border ring; every other mode fills.
    function automatic logic mode_draws(input mode_e m, input logic border);
        return (m != MODE_OUTLINE) || border;
    endfunction

    // True when the pixel takes the secondary colour instead of the primary.
    function automatic logic use_colour_b(input mode_e m, input logic border, input logic parity);
        case (m)
            MODE_CHECKER:  return parity;
            MODE_BORDERED: return !border;
            default:       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/draw_rect_fill_if.sv
// Request and pixel-stream signals of the rectangle rasteriser.
interface draw_rect_fill_if
    import draw_rect_fill_pkg::*;
#(
    parameter int X_W      = X_W_DEF,
    parameter int Y_W      = Y_W_DEF,
    parameter int COLOUR_W = COLOUR_W_DEF
) ();
    logic                start;
    logic [X_W-1:0]      rect_x;
    logic [Y_W-1:0]      rect_y;
    logic [X_W-1:0]      rect_w;
    logic [Y_W-1:0]      rect_h;
    logic [1:0]          mode;
    logic [COLOUR_W-1:0] colour_a;
    logic [COLOUR_W-1:0] colour_b;
    logic                ready;
    logic [X_W-1:0]      x;
    logic [Y_W-1:0]      y;
    logic [COLOUR_W-1:0] colour;
    logic                plot;
    logic                busy;
    logic                done;

    // Rasteriser side.
    modport slave (
        input  start, rect_x, rect_y, rect_w, rect_h, mode, colour_a, colour_b, ready,
        output x, y, colour, plot, busy, done
    );

    // Requester / pixel-sink side.
    modport master (
        output start, rect_x, rect_y, rect_w, rect_h, mode, colour_a, colour_b, ready,
        input  x, y, colour, plot, busy, done
    );
endinterface

// File: rtl/draw_rect_fill_rect_scan_counter.sv
// Column/row raster counter; exposes the next position so the owner can register pixel outputs.
module rect_scan_counter
    import draw_rect_fill_pkg::*;
#(
    parameter int X_W = X_W_DEF,
    parameter int Y_W = Y_W_DEF
) (
    input  logic           clock,
    input  logic           resetn,
    input  logic           clear,
    input  logic           advance,
    input  logic [X_W-1:0] w,
    input  logic [Y_W-1:0] h,
    output logic [X_W-1:0] cu,
    output logic [Y_W-1:0] rv,
    output logic           last,
    output logic [X_W-1:0] nxt_cu,
    output logic [Y_W-1:0] nxt_rv,
    output logic           nxt_border
);
    logic [X_W-1:0] w_m1;
    logic [Y_W-1:0] h_m1;

    assign w_m1 = w - X_W'(1);
    assign h_m1 = h - Y_W'(1);
    assign last = (cu == w_m1) && (rv == h_m1);

    // Next raster position: restart at the origin on clear, otherwise column first.
    always_comb begin
        // NOTE: defaults first so no path through this block leaves a signal unassigned (no latch).
        nxt_cu = cu;
        nxt_rv = rv;
        if (clear) begin
            nxt_cu = '0;
            nxt_rv = '0;
        end else if (cu == w_m1) begin
            nxt_cu = '0;
            nxt_rv = rv + Y_W'(1);
        end else begin
            nxt_cu = cu + X_W'(1);
        end
        // The origin is always a border pixel, and w/h are not latched yet during clear.
        nxt_border = clear || (nxt_cu == '0) || (nxt_cu == w_m1) ||
                     (nxt_rv == '0) || (nxt_rv == h_m1);
    end

    // Position register, loaded on clear or when the current position is consumed.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!resetn) begin
            cu <= '0;
            rv <= '0;
        end else if (clear || advance) begin
            cu <= nxt_cu;
            rv <= nxt_rv;
        end
    end
endmodule

// File: rtl/draw_rect_fill.sv
// Axis-aligned rectangle rasteriser with clipping, four fill modes and ready back-pressure.
module draw_rect_fill
    import draw_rect_fill_pkg::*;
#(
    parameter int X_W      = X_W_DEF,
    parameter int Y_W      = Y_W_DEF,
    parameter int COLOUR_W = COLOUR_W_DEF,
    parameter int SCREEN_W = SCREEN_W_DEF,
    parameter int SCREEN_H = SCREEN_H_DEF
) (
    input logic              clock,
    input logic              resetn,
    draw_rect_fill_if.slave  bus
);
    localparam logic [X_W:0] SX = (X_W+1)'(SCREEN_W);
    localparam logic [Y_W:0] SY = (Y_W+1)'(SCREEN_H);

    state_e              state;
    logic [X_W-1:0]      rx;
    logic [Y_W-1:0]      ry;
    logic [X_W-1:0]      rw;
    logic [Y_W-1:0]      rh;
    mode_e               rmode;
    logic [COLOUR_W-1:0] ca;
    logic [COLOUR_W-1:0] cb;

    logic           accept, empty, clear, step, advance, last, nxt_border;
    logic [X_W-1:0] cu, nxt_cu, base_x;
    logic [Y_W-1:0] rv, nxt_rv, base_y;
    logic [X_W:0]   sum_x;
    logic [Y_W:0]   sum_y;
    mode_e          mode_sel;
    logic [COLOUR_W-1:0] col_a, col_b, pix_colour;
    logic           pix_plot;

    assign accept  = (state == ST_IDLE) && bus.start;
    assign empty   = (bus.rect_w == '0) || (bus.rect_h == '0);
    assign clear   = accept && !empty;
    assign step    = (state == ST_SCAN) && (!bus.plot || bus.ready);
    assign advance = step && !last;

    rect_scan_counter #(.X_W(X_W), .Y_W(Y_W)) u_scan (
        .clock      (clock),
        .resetn     (resetn),
        .clear      (clear),
        .advance    (advance),
        .w          (rw),
        .h          (rh),
        .cu         (cu),
        .rv         (rv),
        .last       (last),
        .nxt_cu     (nxt_cu),
        .nxt_rv     (nxt_rv),
        .nxt_border (nxt_border)
    );

    // Pixel about to be presented: taken from live inputs on acceptance, latched ones afterwards.
    always_comb begin
        base_x   = accept ? bus.rect_x : rx;
        base_y   = accept ? bus.rect_y : ry;
        mode_sel = accept ? mode_e'(bus.mode) : rmode;
        col_a    = accept ? bus.colour_a : ca;
        col_b    = accept ? bus.colour_b : cb;
        // Extra top bit keeps off-screen sums from wrapping back onto the screen.
        sum_x      = {1'b0, base_x} + {1'b0, nxt_cu};
        sum_y      = {1'b0, base_y} + {1'b0, nxt_rv};
        pix_plot   = (sum_x < SX) && (sum_y < SY) && mode_draws(mode_sel, nxt_border);
        pix_colour = use_colour_b(mode_sel, nxt_border, sum_x[0] ^ sum_y[0]) ? col_b : col_a;
    end

    // Control FSM with registered pixel, busy and done outputs.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            bus.x      <= '0;
            bus.y      <= '0;
            bus.colour <= '0;
            bus.plot   <= 1'b0;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
            // NOTE: the latched request is cleared too so an aborted rectangle leaves nothing behind.
            rx    <= '0;
            ry    <= '0;
            rw    <= '0;
            rh    <= '0;
            rmode <= MODE_SOLID;
            ca    <= '0;
            cb    <= '0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        rx    <= bus.rect_x;
                        ry    <= bus.rect_y;
                        rw    <= bus.rect_w;
                        rh    <= bus.rect_h;
                        rmode <= mode_e'(bus.mode);
                        ca    <= bus.colour_a;
                        cb    <= bus.colour_b;
                        if (empty) begin
                            state    <= ST_DONE;
                            bus.done <= 1'b1;
                        end else begin
                            state      <= ST_SCAN;
                            bus.busy   <= 1'b1;
                            bus.x      <= sum_x[X_W-1:0];
                            bus.y      <= sum_y[Y_W-1:0];
                            bus.colour <= pix_colour;
                            bus.plot   <= pix_plot;
                        end
                    end
                end
                ST_SCAN: begin
                    if (step) begin
                        if (last) begin
                            state    <= ST_DONE;
                            bus.busy <= 1'b0;
                            bus.plot <= 1'b0;
                            bus.done <= 1'b1;
                        end else begin
                            bus.x      <= sum_x[X_W-1:0];
                            bus.y      <= sum_y[Y_W-1:0];
                            bus.colour <= pix_colour;
                            bus.plot   <= pix_plot;
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_draw_rect_fill.sv
// Scoreboard bench for draw_rect_fill: stimulus pushes expected scan positions, a monitor pops them.
module tb_draw_rect_fill;
    import draw_rect_fill_pkg::*;

    localparam int XW = 8;
    localparam int YW = 7;
    localparam int CW = 3;
    localparam int SW = 160;
    localparam int SH = 120;

    logic clock = 1'b0;
    logic resetn = 1'b0;
    always #5 clock = ~clock;

    draw_rect_fill_if #(.X_W(XW), .Y_W(YW), .COLOUR_W(CW)) bus ();

    draw_rect_fill #(.X_W(XW), .Y_W(YW), .COLOUR_W(CW), .SCREEN_W(SW), .SCREEN_H(SH)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    typedef struct {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [CW-1:0] colour;
        logic          plot;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int failures = 0;
    int stall_cnt = 0;
    int busy_cnt = 0;
    int plot_cnt = 0;
    int done_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Reference: every scan position in raster order, from the drawing rules; returns pixels plotted.
    function automatic int build(input int rx, input int ry, input int rw, input int rh,
                                 input int m, input int a, input int b);
        int n_plot = 0;
        for (int r = 0; r < rh; r++) begin
            for (int c = 0; c < rw; c++) begin
                exp_t e;
                int sx = rx + c;
                int sy = ry + r;
                bit border = (c == 0) || (c == rw - 1) || (r == 0) || (r == rh - 1);
                int col;
                e.x = sx[XW-1:0];
                e.y = sy[YW-1:0];
                e.plot = (sx < SW) && (sy < SH) && (m != 1 || border);
                case (m)
                    2:       col = ((sx + sy) % 2 == 0) ? a : b;
                    3:       col = border ? a : b;
                    default: col = a;
                endcase
                e.colour = col[CW-1:0];
                if (e.plot) n_plot++;
                exp_q.push_back(e);
            end
        end
        return n_plot;
    endfunction

    // Monitor: consumes one expected position whenever the DUT's position advances.
    initial begin : monitor
        exp_t e;
        logic prev_stall;
        logic [XW-1:0] px;
        logic [YW-1:0] py;
        logic [CW-1:0] pc;
        logic pp;
        prev_stall = 1'b0;
        forever begin
            @(negedge clock);
            if (!resetn) begin
                exp_q.delete();
                prev_stall = 1'b0;
                continue;
            end
            if (prev_stall) begin
                check("hold_x", bus.x, px);
                check("hold_y", bus.y, py);
                check("hold_colour", bus.colour, pc);
                check("hold_plot", bus.plot, pp);
            end
            if (bus.busy) begin
                busy_cnt++;
                if (bus.plot && !bus.ready) begin
                    stall_cnt++;
                end else if (exp_q.size() == 0) begin
                    check("extra_position", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("plot", bus.plot, e.plot);
                    check("x", bus.x, e.x);
                    check("y", bus.y, e.y);
                    if (e.plot) check("colour", bus.colour, e.colour);
                    if (bus.plot) plot_cnt++;
                end
            end else begin
                check("idle_plot", bus.plot, 0);
            end
            if (bus.done) begin
                done_cnt++;
                check("missing_positions", exp_q.size(), 0);
            end
            prev_stall = bus.busy && bus.plot && !bus.ready;
            px = bus.x;
            py = bus.y;
            pc = bus.colour;
            pp = bus.plot;
        end
    end

    task automatic junk_inputs();
        bus.rect_x   = XW'($urandom);
        bus.rect_y   = YW'($urandom);
        bus.rect_w   = XW'($urandom);
        bus.rect_h   = YW'($urandom);
        bus.mode     = 2'($urandom);
        bus.colour_a = CW'($urandom);
        bus.colour_b = CW'($urandom);
    endtask

    // Issue one rectangle at the start of a cycle; ready_kind 0 high, 1 random, 2 directed stall.
    task automatic run_rect(input int rx, input int ry, input int rw, input int rh,
                            input int m, input int a, input int b,
                            input int ready_kind, input int stall_at, input int stall_len,
                            input int restart_at, output int done_cyc);
        int n, exp_plot, cyc;
        n = rw * rh;
        exp_plot = build(rx, ry, rw, rh, m, a, b);
        stall_cnt = 0;
        busy_cnt  = 0;
        plot_cnt  = 0;
        done_cnt  = 0;
        bus.start    = 1'b1;
        bus.rect_x   = XW'(rx);
        bus.rect_y   = YW'(ry);
        bus.rect_w   = XW'(rw);
        bus.rect_h   = YW'(rh);
        bus.mode     = 2'(m);
        bus.colour_a = CW'(a);
        bus.colour_b = CW'(b);
        bus.ready    = 1'b1;
        cyc = 0;
        done_cyc = -1;
        while (done_cyc < 0 && cyc < 4 * n + 40) begin
            @(posedge clock); #1;
            cyc++;
            bus.start = (cyc == restart_at);
            junk_inputs();
            case (ready_kind)
                1:       bus.ready = ($urandom_range(0, 3) != 0);
                2:       bus.ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
                default: bus.ready = 1'b1;
            endcase
            @(negedge clock);
            if (bus.done) done_cyc = cyc;
        end
        check("done_before_timeout", done_cyc >= 0, 1);
        check("done_cycle", done_cyc, n + 1 + stall_cnt);
        check("busy_cycles", busy_cnt, n + stall_cnt);
        check("plotted_count", plot_cnt, exp_plot);
        @(posedge clock); #1;
        bus.start = 1'b0;
        bus.ready = 1'b1;
        @(negedge clock);
        check("done_one_cycle", bus.done, 0);
        check("done_pulses", done_cnt, 1);
        check("idle_busy", bus.busy, 0);
        @(posedge clock); #1;
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int dc;
        bus.start = 1'b0;
        bus.ready = 1'b1;
        bus.rect_x = '0; bus.rect_y = '0; bus.rect_w = '0; bus.rect_h = '0;
        bus.mode = '0; bus.colour_a = '0; bus.colour_b = '0;
        repeat (3) @(posedge clock);
        #1 resetn = 1'b1;
        @(negedge clock);
        check("reset_x", bus.x, 0);
        check("reset_y", bus.y, 0);
        check("reset_colour", bus.colour, 0);
        check("reset_plot", bus.plot, 0);
        check("reset_busy", bus.busy, 0);
        check("reset_done", bus.done, 0);
        @(posedge clock); #1;

        // Full-screen solid background.
        run_rect(0, 0, 160, 120, 0, 3'b010, 0, 0, 0, 0, -1, dc);
        check("full_done_cycle", dc, 19201);
        check("full_plotted", plot_cnt, 19200);

        // Checker, with an ignored start while busy.
        run_rect(5, 4, 3, 2, 2, 1, 6, 0, 0, 0, 3, dc);
        check("checker_done_cycle", dc, 7);
        check("checker_busy", busy_cnt, 6);

        // Outline: interior positions consume cycles but are not plotted.
        run_rect(10, 10, 4, 3, 1, 5, 2, 0, 0, 0, -1, dc);
        check("outline_done_cycle", dc, 13);
        check("outline_plotted", plot_cnt, 10);

        // Back-pressure: pixel 1 stalled for three cycles.
        run_rect(20, 30, 2, 2, 0, 5, 1, 2, 2, 3, -1, dc);
        check("bp_stalls", stall_cnt, 3);
        check("bp_done_cycle", dc, 8);

        // Clipping at the bottom-right corner.
        run_rect(158, 118, 4, 4, 3, 4, 7, 0, 0, 0, -1, dc);
        check("clip_done_cycle", dc, 17);
        check("clip_plotted", plot_cnt, 4);

        // Empty rectangle.
        run_rect(40, 40, 0, 5, 0, 7, 0, 0, 0, 0, -1, dc);
        check("empty_done_cycle", dc, 1);
        check("empty_plotted", plot_cnt, 0);

        // Reset mid-rectangle aborts without a done pulse.
        void'(build(30, 20, 6, 4, 3, 2, 5));
        bus.start = 1'b1;
        bus.rect_x = 8'd30; bus.rect_y = 7'd20; bus.rect_w = 8'd6; bus.rect_h = 7'd4;
        bus.mode = 2'd3; bus.colour_a = 3'd2; bus.colour_b = 3'd5;
        @(posedge clock); #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clock);
        #1 resetn = 1'b0;
        @(posedge clock); #1;
        resetn = 1'b1;
        done_cnt = 0;
        @(negedge clock);
        check("abort_plot", bus.plot, 0);
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        repeat (30) @(posedge clock);
        check("abort_no_done", done_cnt, 0);
        #1;

        // Fresh rectangle after the abort, then randomized traffic.
        run_rect(30, 20, 6, 4, 3, 2, 5, 0, 0, 0, -1, dc);
        for (int i = 0; i < 30; i++) begin
            int rx, ry, rw, rh;
            rx = $urandom_range(0, 255);
            if (i % 2 == 0) rx = $urandom_range(140, 170);
            ry = $urandom_range(0, 127);
            if (i % 3 == 0) ry = $urandom_range(105, 127);
            rw = $urandom_range(0, 12);
            rh = $urandom_range(0, 8);
            run_rect(rx, ry, rw, rh, $urandom_range(0, 3), $urandom_range(0, 7),
                     $urandom_range(0, 7), 1, 0, 0, $urandom_range(1, 6), dc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
